// File: rtl/mem_loader.sv
// Boot loader and memory-port arbiter: assembles a length-prefixed little-endian
// byte stream into 32-bit words, writes them while holding the CPU, then hands the memory port to the CPU.
module mem_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int LOAD_BASE  = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        cpu_mem_we,
  input  logic [31:0] cpu_mem_addr,
  input  logic [31:0] cpu_mem_wdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        error,
  output logic [15:0] words_loaded,
  output logic [2:0]  dbg_state
);

  // Stream handshake: a byte moves on any rising edge where rx_valid && rx_ready;
  // rx_valid may drop at any time (gaps stall), and rx_ready never waits on rx_valid.

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR0  = 3'd1;
  localparam logic [2:0] S_HDR1  = 3'd2;
  localparam logic [2:0] S_BYTES = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  // Largest word count that still fits between LOAD_BASE and the top of memory.
  localparam logic [31:0] LP_CAPACITY = 32'((1 << ADDR_WIDTH) - LOAD_BASE);

  logic [2:0]  r_state;
  logic [7:0]  r_n_lo;
  logic [15:0] r_n;
  logic [1:0]  r_byte_idx;
  logic [31:0] r_word;
  logic [15:0] r_word_idx;
  logic        r_error;

  logic [2:0]  w_state_next;
  logic        w_xfer;
  logic        w_restart;
  logic [15:0] w_n_full;
  logic        w_n_zero;
  logic        w_n_over;
  logic [15:0] w_count_next;
  logic [31:0] w_word_addr;
  logic        w_loader_we;
  logic        w_pass;

  assign rx_ready     = (r_state == S_HDR0) || (r_state == S_HDR1) || (r_state == S_BYTES);
  assign w_xfer       = rx_valid && rx_ready;
  assign w_restart    = load_start &&
                        ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
  assign w_n_full     = {rx_data, r_n_lo};
  assign w_n_zero     = (w_n_full == 16'd0);
  assign w_n_over     = ({16'd0, w_n_full} > LP_CAPACITY);
  assign w_count_next = r_word_idx + 16'd1;
  assign w_word_addr  = 32'(LOAD_BASE) + {16'd0, r_word_idx};

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (load_start) w_state_next = S_HDR0;
      end
      S_HDR0: begin
        if (w_xfer) w_state_next = S_HDR1;
      end
      S_HDR1: begin
        if (w_xfer) begin
          if (w_n_zero)      w_state_next = S_DONE;
          else if (w_n_over) w_state_next = S_ERR;
          else               w_state_next = S_BYTES;
        end
      end
      S_BYTES: begin
        if (w_xfer && (r_byte_idx == 2'd3)) w_state_next = S_WRITE;
      end
      S_WRITE: begin
        if (w_count_next == r_n) w_state_next = S_DONE;
        else                     w_state_next = S_BYTES;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_n_lo     <= 8'd0;
      r_n        <= 16'd0;
      r_byte_idx <= 2'd0;
      r_word     <= 32'd0;
      r_word_idx <= 16'd0;
      r_error    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_restart) begin
        r_n_lo     <= 8'd0;
        r_n        <= 16'd0;
        r_byte_idx <= 2'd0;
        r_word     <= 32'd0;
        r_word_idx <= 16'd0;
        r_error    <= 1'b0;
      end
      if ((r_state == S_HDR0) && w_xfer) r_n_lo <= rx_data;
      if ((r_state == S_HDR1) && w_xfer) begin
        r_n <= w_n_full;
        if (!w_n_zero && w_n_over) r_error <= 1'b1;
      end
      // Little-endian: byte k lands in bits [8k+7:8k]; the index wraps after byte 3.
      if ((r_state == S_BYTES) && w_xfer) begin
        r_word[{r_byte_idx, 3'b000} +: 8] <= rx_data;
        r_byte_idx                        <= r_byte_idx + 2'd1;
      end
      if (r_state == S_WRITE) r_word_idx <= w_count_next;
    end
  end

  assign w_loader_we = (r_state == S_WRITE);
  assign w_pass      = (r_state == S_DONE);

  // CPU inputs reach memory only in DONE; while held they are fully masked.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    if (w_loader_we) begin
      mem_we    = 1'b1;
      mem_addr  = {w_word_addr[29:0], 2'b00};
      mem_wdata = r_word;
    end else if (w_pass) begin
      mem_we    = cpu_mem_we;
      mem_addr  = cpu_mem_addr;
      mem_wdata = cpu_mem_wdata;
    end
  end

  assign cpu_hold     = (r_state != S_DONE);
  assign busy         = (r_state == S_HDR0) || (r_state == S_HDR1) ||
                        (r_state == S_BYTES) || (r_state == S_WRITE);
  assign error        = r_error;
  assign words_loaded = r_word_idx;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: header/payload streams, backpressure, empty and
// oversize loads, mid-load reset, and CPU pass-through/masking.
module tb_mem_loader;

  logic        clk;
  logic        reset;
  logic        load_start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        cpu_mem_we;
  logic [31:0] cpu_mem_addr;
  logic [31:0] cpu_mem_wdata;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        error;
  logic [15:0] words_loaded;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];

  mem_loader #(.ADDR_WIDTH(10), .LOAD_BASE(0)) dut (
    .clk(clk), .reset(reset), .load_start(load_start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .cpu_mem_we(cpu_mem_we), .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wdata(cpu_mem_wdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .error(error),
    .words_loaded(words_loaded), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every memory write issued while the CPU is held must be an expected loader write.
  always @(negedge clk) begin
    if (mem_we && cpu_hold) begin
      check_eq("sb_write_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) check_eq("sb_write_addr_data", {mem_addr, mem_wdata}, exp_q.pop_front());
    end
  end

  // drivers (all called and returning at a falling edge)
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check_eq("rx_ready_timeout", 64'd0, 64'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic send_header(input logic [15:0] n, input int gap);
    send_byte(n[7:0]);
    idle(gap);
    send_byte(n[15:8]);
  endtask

  // Returns in the WRITE cycle of this word.
  task automatic send_word(input logic [31:0] w, input logic [31:0] addr, input int gap);
    exp_q.push_back({addr, w});
    for (int k = 0; k < 4; k++) begin
      send_byte(w[8*k +: 8]);
      if (k != 3) idle((k % 2 == 0) ? gap : 0);
    end
    check_eq("write_cycle_we", 64'(mem_we), 64'd1);
    check_eq("write_cycle_addr", 64'(mem_addr), 64'(addr));
    check_eq("write_cycle_data", 64'(mem_wdata), 64'(w));
    check_eq("write_cycle_rx_ready", 64'(rx_ready), 64'd0);
  endtask

  task automatic check_done(input logic [15:0] n_words);
    check_eq("done_cpu_hold", 64'(cpu_hold), 64'd0);
    check_eq("done_busy", 64'(busy), 64'd0);
    check_eq("done_words_loaded", 64'(words_loaded), 64'(n_words));
  endtask

  initial begin
    reset = 1'b1; load_start = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    cpu_mem_we = 1'b0; cpu_mem_addr = 32'h0; cpu_mem_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // reset state
    check_eq("rst_cpu_hold", 64'(cpu_hold), 64'd1);
    check_eq("rst_rx_ready", 64'(rx_ready), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_error", 64'(error), 64'd0);
    check_eq("rst_words_loaded", 64'(words_loaded), 64'd0);

    // hold masking before any load
    cpu_mem_we = 1'b1; cpu_mem_addr = 32'h10; cpu_mem_wdata = 32'hA5;
    #1;
    check_eq("mask_pre_load_we", 64'(mem_we), 64'd0);
    @(negedge clk);
    cpu_mem_we = 1'b0;

    // basic two-word load
    pulse_start();
    check_eq("basic_busy", 64'(busy), 64'd1);
    send_header(16'd2, 0);
    send_word(32'h12345678, 32'h0, 0);
    send_word(32'hDEADBEEF, 32'h4, 0);
    check_eq("basic_hold_in_write", 64'(cpu_hold), 64'd1);
    @(negedge clk);
    check_done(16'd2);

    // backpressure: 3-cycle gap after every odd-numbered stream byte
    pulse_start();
    check_eq("bp_hold_rises", 64'(cpu_hold), 64'd1);
    send_header(16'd2, 3);
    send_word(32'h12345678, 32'h0, 3);
    send_word(32'hDEADBEEF, 32'h4, 3);
    @(negedge clk);
    check_done(16'd2);

    // empty load
    pulse_start();
    send_header(16'd0, 0);
    check_done(16'd0);

    // overflow: N = 1025 exceeds 1024 words
    pulse_start();
    send_header(16'h0401, 0);
    check_eq("ovf_error", 64'(error), 64'd1);
    check_eq("ovf_cpu_hold", 64'(cpu_hold), 64'd1);
    check_eq("ovf_rx_ready", 64'(rx_ready), 64'd0);
    rx_valid = 1'b1; rx_data = 8'h99; cpu_mem_we = 1'b1;
    idle(5);
    check_eq("ovf_error_sticky", 64'(error), 64'd1);
    rx_valid = 1'b0; cpu_mem_we = 1'b0;
    pulse_start();
    check_eq("ovf_error_cleared", 64'(error), 64'd0);
    check_eq("ovf_restart_busy", 64'(busy), 64'd1);

    // reset mid-load: 5 payload bytes of a 2-word load
    send_header(16'd2, 0);
    send_word(32'h11223344, 32'h0, 0);
    send_byte(8'h55);
    reset = 1'b1;
    @(negedge clk);
    check_eq("midrst_cpu_hold", 64'(cpu_hold), 64'd1);
    check_eq("midrst_busy", 64'(busy), 64'd0);
    check_eq("midrst_rx_ready", 64'(rx_ready), 64'd0);
    check_eq("midrst_words_loaded", 64'(words_loaded), 64'd0);
    reset = 1'b0;
    idle(6);
    check_eq("midrst_still_idle_hold", 64'(cpu_hold), 64'd1);

    // load_start with a byte waiting in IDLE: the byte must not be consumed there
    rx_data = 8'h01; rx_valid = 1'b1; load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    send_byte(8'h01);
    send_byte(8'h00);
    send_word(32'hCAFEF00D, 32'h0, 0);
    @(negedge clk);
    check_done(16'd1);

    // zero-latency pass-through in DONE
    cpu_mem_we = 1'b1; cpu_mem_addr = 32'h10; cpu_mem_wdata = 32'hA5;
    #1;
    check_eq("pass_we", 64'(mem_we), 64'd1);
    check_eq("pass_addr", 64'(mem_addr), 64'h10);
    check_eq("pass_wdata", 64'(mem_wdata), 64'hA5);
    @(negedge clk);
    cpu_mem_we = 1'b0;
    #1;
    check_eq("pass_we_low", 64'(mem_we), 64'd0);

    idle(2);
    check_eq("sb_all_writes_seen", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
